// File: rtl/bus_arbiter8.sv
// Round-robin arbiter granting one of eight requesters a shared single-port resource.
// Optional forced-release timeout is built only when ARB_TIMEOUT_EN is defined.
module bus_arbiter8 #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_next;
  logic [2:0] last, last_next;
  logic [7:0] gnt_next;
  logic [2:0] sel_next;
  logic       busy_next;
  logic       timeout_err_next;
  logic [2:0] winner;
  logic       any_req;
  logic       timeout_hit;
  logic       release_now;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : g_cfg_check
    $error("bus_arbiter8: TIMEOUT_CYCLES must lie in 1 .. 2**CNT_W-1");
  end

  // Scan last+1 .. last+8 so the previous winner is considered last.
  always_comb begin
    logic [2:0] idx;
    logic       found;
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             grant_now;

  // Fires on the edge that would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == BUSY) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign grant_now   = busy_next && ((state == IDLE) || release_now);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (grant_now) begin
      cnt <= '0;
    end else if (state == BUSY && !done) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign release_now = (state == BUSY) && (done || timeout_hit);

  always_comb begin
    state_next       = state;
    last_next        = last;
    gnt_next         = gnt;
    sel_next         = sel;
    busy_next        = busy;
    timeout_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = BUSY;
          last_next  = winner;
          gnt_next   = 8'(1) << winner;
          sel_next   = winner;
          busy_next  = 1'b1;
        end
      end
      BUSY: begin
        if (release_now) begin
          timeout_err_next = timeout_hit && !done;
          if (any_req) begin
            last_next = winner;
            gnt_next  = 8'(1) << winner;
            sel_next  = winner;
            busy_next = 1'b1;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            busy_next  = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 3'd7;
      gnt         <= '0;
      sel         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      last        <= last_next;
      gnt         <= gnt_next;
      sel         <= sel_next;
      busy        <= busy_next;
      timeout_err <= timeout_err_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed self-checking bench for bus_arbiter8; covers both ARB_TIMEOUT_EN builds.
module tb_bus_arbiter8;

  localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  bus_arbiter8 #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task step();
    @(posedge clk);
    #1;
  endtask

  task do_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task test_reset();
    rst = 1'b1; req = 8'hFF; done = 1'b0;
    #3;
    step();
    tests_run++; if (gnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_gnt: got %h expected %h", gnt, 8'h00); end
    tests_run++; if (sel !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_sel: got %0d expected %0d", sel, 0); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_terr: got %b expected %b", timeout_err, 1'b0); end
    rst = 1'b0;
    step();
    tests_run++; if (gnt !== 8'h01) begin tests_failed++; $display("[TB] FAIL first_gnt: got %h expected %h", gnt, 8'h01); end
    tests_run++; if (sel !== 3'd0) begin tests_failed++; $display("[TB] FAIL first_sel: got %0d expected %0d", sel, 0); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL first_busy: got %b expected %b", busy, 1'b1); end
  endtask

  // Starts from the grant to requester 0 left by test_reset.
  task test_rotation();
    logic [7:0] exp_gnt;
    req = 8'hFF; done = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_gnt = 8'h01 << (k % 8);
      tests_run++; if (gnt !== exp_gnt) begin tests_failed++; $display("[TB] FAIL rot_gnt%0d: got %h expected %h", k, gnt, exp_gnt); end
      tests_run++; if (sel !== 3'(k % 8)) begin tests_failed++; $display("[TB] FAIL rot_sel%0d: got %0d expected %0d", k, sel, k % 8); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rot_busy%0d: got %b expected %b", k, busy, 1'b1); end
    end
    done = 1'b0;
  endtask

  task test_skip();
    do_reset();
    req = 8'h04;
    step();
    tests_run++; if (gnt !== 8'h04) begin tests_failed++; $display("[TB] FAIL skip_setup: got %h expected %h", gnt, 8'h04); end
    req = 8'b0010_0100; done = 1'b1;
    step();
    tests_run++; if (gnt !== 8'h20) begin tests_failed++; $display("[TB] FAIL skip_gnt5: got %h expected %h", gnt, 8'h20); end
    tests_run++; if (sel !== 3'd5) begin tests_failed++; $display("[TB] FAIL skip_sel5: got %0d expected %0d", sel, 5); end
    step();
    tests_run++; if (gnt !== 8'h04) begin tests_failed++; $display("[TB] FAIL skip_gnt2: got %h expected %h", gnt, 8'h04); end
    tests_run++; if (sel !== 3'd2) begin tests_failed++; $display("[TB] FAIL skip_sel2: got %0d expected %0d", sel, 2); end
    done = 1'b0;
  endtask

  task test_held_grant();
    do_reset();
    req = 8'h08;
    step();
    tests_run++; if (gnt !== 8'h08) begin tests_failed++; $display("[TB] FAIL held_setup: got %h expected %h", gnt, 8'h08); end
    req = 8'h40;
    repeat (HOLD) step();
    tests_run++; if (gnt !== 8'h08) begin tests_failed++; $display("[TB] FAIL held_gnt: got %h expected %h", gnt, 8'h08); end
    tests_run++; if (sel !== 3'd3) begin tests_failed++; $display("[TB] FAIL held_sel: got %0d expected %0d", sel, 3); end
    done = 1'b1;
    step();
    tests_run++; if (gnt !== 8'h40) begin tests_failed++; $display("[TB] FAIL held_next: got %h expected %h", gnt, 8'h40); end
    tests_run++; if (sel !== 3'd6) begin tests_failed++; $display("[TB] FAIL held_next_sel: got %0d expected %0d", sel, 6); end
    req = 8'h00;
    step();
    tests_run++; if (gnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL idle_gnt: got %h expected %h", gnt, 8'h00); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_busy: got %b expected %b", busy, 1'b0); end
    step();
    tests_run++; if (gnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL idle_done_gnt: got %h expected %h", gnt, 8'h00); end
    tests_run++; if (sel !== 3'd6) begin tests_failed++; $display("[TB] FAIL idle_sel_hold: got %0d expected %0d", sel, 6); end
    done = 1'b0;
  endtask

  task test_timeout();
    do_reset();
    req = 8'h02;
    step();
    tests_run++; if (gnt !== 8'h02) begin tests_failed++; $display("[TB] FAIL to_setup: got %h expected %h", gnt, 8'h02); end
    req = 8'h22;
`ifdef ARB_TIMEOUT_EN
    repeat (3) step();
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_early_err: got %b expected %b", timeout_err, 1'b0); end
    tests_run++; if (gnt !== 8'h02) begin tests_failed++; $display("[TB] FAIL to_early_gnt: got %h expected %h", gnt, 8'h02); end
    step();
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_err: got %b expected %b", timeout_err, 1'b1); end
    tests_run++; if (gnt !== 8'h20) begin tests_failed++; $display("[TB] FAIL to_move_gnt: got %h expected %h", gnt, 8'h20); end
    step();
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_pulse_len: got %b expected %b", timeout_err, 1'b0); end
    repeat (2) step();
    done = 1'b1;
    step();
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_done_tie: got %b expected %b", timeout_err, 1'b0); end
    tests_run++; if (gnt !== 8'h02) begin tests_failed++; $display("[TB] FAIL to_done_gnt: got %h expected %h", gnt, 8'h02); end
    done = 1'b0; req = 8'h00;
    repeat (4) step();
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_idle_err: got %b expected %b", timeout_err, 1'b1); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_idle_busy: got %b expected %b", busy, 1'b0); end
`else
    begin
      logic saw_err = 1'b0;
      for (int i = 0; i < 310; i++) begin
        step();
        if (timeout_err) saw_err = 1'b1;
      end
      tests_run++; if (gnt !== 8'h02) begin tests_failed++; $display("[TB] FAIL hold_300_gnt: got %h expected %h", gnt, 8'h02); end
      tests_run++; if (saw_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_300_err: got %b expected %b", saw_err, 1'b0); end
    end
`endif
    req = 8'h00;
  endtask

  task test_async_reset();
    do_reset();
    req = 8'h10;
    step();
    tests_run++; if (gnt !== 8'h10) begin tests_failed++; $display("[TB] FAIL ar_setup: got %h expected %h", gnt, 8'h10); end
    #3;
    rst = 1'b1;
    #1;
    tests_run++; if (gnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL ar_gnt: got %h expected %h", gnt, 8'h00); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ar_busy: got %b expected %b", busy, 1'b0); end
    tests_run++; if (sel !== 3'd0) begin tests_failed++; $display("[TB] FAIL ar_sel: got %0d expected %0d", sel, 0); end
    step();
    rst = 1'b0;
    step();
    tests_run++; if (gnt !== 8'h10) begin tests_failed++; $display("[TB] FAIL ar_regrant: got %h expected %h", gnt, 8'h10); end
    tests_run++; if (sel !== 3'd4) begin tests_failed++; $display("[TB] FAIL ar_resel: got %0d expected %0d", sel, 4); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_skip();
    test_held_grant();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter8.md
# bus_arbiter8

Round-robin arbiter that shares one single-port datapath resource (the shared memory/bus port) among eight requesters. It owns the 3-bit select of the 8:1 request multiplexer in front of that resource and keeps a grant until the resource signals completion. It is instantiated next to that multiplexer, with its `sel` output wired straight to the mux select.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum BUSY cycles before forced release. Used only when `ARB_TIMEOUT_EN` is defined.
- `CNT_W`, default 8: width of the timeout counter. Requires `TIMEOUT_CYCLES < 2**CNT_W`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 8: request lines, one bit per requester. Level-sensitive.
- `done` input 1: shared resource finished the current transaction. Sampled only in BUSY.
- `gnt` output 8: one-hot grant. All zero when idle. Registered.
- `sel` output 3: binary index of the granted requester, driven to the mux select. Registered.
- `busy` output 1: high while a grant is held. Registered.
- `timeout_err` output 1: one-cycle pulse on forced release. Tied 0 when `ARB_TIMEOUT_EN` is undefined.

## Operation
- FSM has two states: IDLE and BUSY. Internal pointer `last[2:0]` holds the index of the most recent winner.
- Reset (asynchronous) sets:
  - state=IDLE, `gnt`=0, `sel`=0, `busy`=0, `timeout_err`=0.
  - `last`=7, so requester 0 has highest priority first.
  - timeout counter=0.
- Arbitration function: scan indices `last+1`, `last+2`, … `last+8` (mod 8). The first index with `req` set wins. The previous winner therefore has lowest priority.
- IDLE, `req`≠0: winner w is registered, giving `gnt`=1<<w, `sel`=w, `busy`=1, `last`=w. State goes to BUSY.
- IDLE, `req`=0: outputs hold at `gnt`=0 and `busy`=0. `sel` keeps its last value.
- BUSY, `done`=0: `gnt`, `sel` and `busy` hold. The winner dropping its `req` does not release the grant.
- BUSY, `done`=1: the grant is released at this edge and arbitration runs in the same cycle, with `last` already equal to the current winner.
  - Another request pending: the new winner is granted at this edge. No idle bubble between grants.
  - None pending: state goes to IDLE with `gnt`=0 and `busy`=0.
  - The releasing requester, if still requesting, competes at lowest priority.
- `done` while in IDLE is ignored.
- `gnt` is never multi-hot. `sel` always equals the index of the set `gnt` bit whenever `busy`=1.

## Timing
- Grant latency is 1 cycle: a `req` seen at edge N in IDLE gives `gnt` valid after edge N.
- Release latency is 0 cycles after `done`: `done` sampled high at edge N changes `gnt` at edge N, either to a new grant or to 0.
- A single requester holding `req` continuously with `done` pulsing is regranted every transaction with no gap.
- `rst` asserted mid-transaction clears all outputs immediately, without waiting for a clock. The first grant after reset goes to the lowest requesting index.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A `CNT_W`-bit counter clears on every new grant and increments each BUSY cycle with `done`=0.
  - When the counter reaches `TIMEOUT_CYCLES`, that edge acts exactly as `done`=1 (release plus re-arbitration), and `timeout_err` pulses high for 1 cycle.
  - `done` and timeout in the same cycle: treated as a normal `done`, with `timeout_err`=0.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `timeout_err` is tied 0.
  - The grant holds indefinitely until `done`.

## Test plan
- Reset and idle: assert `rst` with `req`=8'hFF → `gnt`=0, `sel`=0, `busy`=0 while in reset. After release, the first edge gives `gnt`=8'h01, `sel`=0.
- Rotation: hold `req`=8'hFF and pulse `done` each grant → `sel` sequence 0,1,2,…,7,0 with no idle cycles between grants.
- Skip and lowest priority: `last`=2 and `req`=8'b0010_0100 → grant index 5. After `done` with `req` unchanged → grant index 2.
- Held grant: grant index 3, drop `req[3]`, keep `done`=0 for 10 cycles while `req[6]`=1 → `gnt`=8'h08 stays. `done` → `gnt`=8'h40.
- Timeout (macro on, `TIMEOUT_CYCLES`=4): grant index 1 with `done` held 0 → after 4 BUSY cycles `timeout_err`=1 for one cycle and the grant moves on (or goes to 0 if no requests). With the macro off → the grant holds for more than 300 cycles.
- Async reset mid-BUSY: assert `rst` between edges while `gnt`=8'h10 → outputs go to 0 before the next edge. After release with `req`=8'h10 → `gnt`=8'h10.
